// File: rtl/pipeline_pkg.sv
// Shared constants for the 5-stage pipeline controller: forwarding selects,
// run-control state encoding and the hardwired zero register.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero is never a real producer, so it never matches.
    function automatic logic reg_match(input logic [4:0] prod, input logic [4:0] cons);
        return (prod != REG_ZERO) && (prod == cons);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select generation; EX/MEM result beats MEM/WB result.
module forward_unit
    import pipeline_pkg::*;
(
    input  logic       en_i,
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] m_rd_i,
    input  logic       m_regwrite_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwrite_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (en_i) begin
            if (m_regwrite_i && reg_match(m_rd_i, ex_rs_i)) begin
                fwd_a_o = FWD_MEM;
            end else if (wb_regwrite_i && reg_match(wb_rd_i, ex_rs_i)) begin
                fwd_a_o = FWD_WB;
            end
            if (m_regwrite_i && reg_match(m_rd_i, ex_rt_i)) begin
                fwd_b_o = FWD_MEM;
            end else if (wb_regwrite_i && reg_match(wb_rd_i, ex_rt_i)) begin
                fwd_b_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/flush/forwarding controller for the 5-stage MIPS pipeline,
// with debug halt/single-step run control and stall/flush event counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic [4:0]  EX_Rs,
    input  logic [4:0]  EX_Rt,
    input  logic [4:0]  EX_Rd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  M_Rd,
    input  logic        M_RegWrite,
    input  logic [4:0]  WB_Rd,
    input  logic        WB_RegWrite,
    input  logic        M_Redirect,
    input  logic        MemBusy,
    input  logic        DbgHalt,
    input  logic        DbgStep,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        EXMEM_Flush,
    output logic        PipeEn,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        Halted,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);

    logic [0:0]  state_q, state_d;
    logic [31:0] stall_cnt_q, flush_cnt_q;

    logic ex_hit, m_hit, wb_hit;
    logic load_use, raw_hazard, stall;
    logic frozen, active, do_redirect, do_stall;

    assign ex_hit = (ID_UseRs && reg_match(EX_Rd, ID_Rs)) || (ID_UseRt && reg_match(EX_Rd, ID_Rt));
    assign m_hit  = (ID_UseRs && reg_match(M_Rd, ID_Rs))  || (ID_UseRt && reg_match(M_Rd, ID_Rt));
    assign wb_hit = (ID_UseRs && reg_match(WB_Rd, ID_Rs)) || (ID_UseRt && reg_match(WB_Rd, ID_Rt));

    assign load_use   = EX_MemRead && ex_hit;
    assign raw_hazard = (EX_RegWrite && ex_hit) || (M_RegWrite && m_hit)
                      || (!RF_BYPASS && WB_RegWrite && wb_hit);
    assign stall      = FWD_EN ? load_use : raw_hazard;

    // A step pulse lets exactly one halted cycle behave like a normal cycle.
    assign frozen      = MemBusy || ((state_q == HALTED) && !DbgStep);
    assign active      = Reset && !frozen;
    assign do_redirect = active && M_Redirect;
    assign do_stall    = active && !M_Redirect && stall;

    assign PCWrite     = active && !do_stall;
    assign IFID_Write  = active && !do_stall;
    assign IFID_Flush  = do_redirect;
    assign IDEX_Flush  = do_redirect || do_stall;
    assign EXMEM_Flush = do_redirect;
    assign PipeEn      = active;
    assign Halted      = (state_q == HALTED);
    assign StallCnt    = stall_cnt_q;
    assign FlushCnt    = flush_cnt_q;

    forward_unit u_forward_unit (
        .en_i          (FWD_EN && Reset),
        .ex_rs_i       (EX_Rs),
        .ex_rt_i       (EX_Rt),
        .m_rd_i        (M_Rd),
        .m_regwrite_i  (M_RegWrite),
        .wb_rd_i       (WB_Rd),
        .wb_regwrite_i (WB_RegWrite),
        .fwd_a_o       (ForwardA),
        .fwd_b_o       (ForwardB)
    );

    always_comb begin
        state_d = state_q;
        if (!MemBusy) begin
            case (state_q)
                RUN:     if (DbgHalt)  state_d = HALTED;
                HALTED:  if (!DbgHalt) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (do_stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (do_redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB).
- Generates PC/IF-ID write enables, per-stage flush (bubble) controls and EX-stage operand forwarding selects.
- Adds debug run control (halt/single-step) and two 32-bit performance counters (stall cycles, flush events).
- Sits beside the datapath; consumes register indices and control bits from the pipeline registers, drives their enable/flush inputs.

Parameters:
- FWD_EN, 1, 1 = forwarding from EX/MEM and MEM/WB enabled; 0 = forwarding off, stall on every RAW hazard.
- RF_BYPASS, 0, 1 = register file is write-before-read, so there is no hazard against the WB producer; 0 = the WB producer counts as a hazard (only when FWD_EN=0).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ID_Rs  in  5  rs field, instruction in ID.
- ID_Rt  in  5  rt field, instruction in ID.
- ID_UseRs  in  1  ID instruction reads rs.
- ID_UseRt  in  1  ID instruction reads rt.
- EX_Rs  in  5  rs of the EX instruction.
- EX_Rt  in  5  rt of the EX instruction.
- EX_Rd  in  5  destination after the RegDst mux.
- EX_RegWrite  in  1  EX instruction writes the register file.
- EX_MemRead  in  1  EX instruction is a load.
- M_Rd  in  5  MEM-stage destination.
- M_RegWrite  in  1  MEM-stage instruction writes the register file.
- WB_Rd  in  5  WB-stage destination.
- WB_RegWrite  in  1  WB-stage instruction writes the register file.
- M_Redirect  in  1  taken branch, j, jal or jr resolved in MEM.
- MemBusy  in  1  data memory not ready; freeze the whole pipeline.
- DbgHalt  in  1  level; request halt.
- DbgStep  in  1  one-cycle pulse; advance one cycle while halted.
- PCWrite  out  1  PC load enable.
- IFID_Write  out  1  IF/ID register enable.
- IFID_Flush  out  1  clear IF/ID to a NOP.
- IDEX_Flush  out  1  clear ID/EX control bits (bubble).
- EXMEM_Flush  out  1  clear EX/MEM control bits.
- PipeEn  out  1  global enable for the ID/EX, EX/MEM and MEM/WB registers.
- ForwardA  out  2  ALU A source: 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result.
- ForwardB  out  2  ALU B source, same encoding as ForwardA.
- Halted  out  1  controller is in the HALTED state.
- StallCnt  out  32  count of load-use/RAW stall cycles.
- FlushCnt  out  32  count of redirect events.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State = RUN.
  - StallCnt = 0, FlushCnt = 0.
  - Outputs during reset: PCWrite=0, IFID_Write=0, PipeEn=0, all flushes=0, Forward*=00, Halted=0.
- Hazard rule:
  - Register 0 never matches for hazard or forwarding.
  - A match on rs counts only when ID_UseRs=1; a match on rt only when ID_UseRt=1.
- Load-use stall (FWD_EN=1):
  - Condition: EX_MemRead & EX_Rd!=0 & EX_Rd matches ID_Rs or ID_Rt.
  - Action: PCWrite=0, IFID_Write=0, IDEX_Flush=1.
  - Lasts exactly 1 cycle per load.
- RAW stall (FWD_EN=0):
  - Condition: any match against EX_Rd (EX_RegWrite) or M_Rd (M_RegWrite); also against WB_Rd (WB_RegWrite) when RF_BYPASS=0.
  - Action: same as the load-use stall, repeated every cycle until no match remains.
- Forwarding (combinational, same cycle):
  - ForwardA=10 if M_RegWrite & M_Rd!=0 & M_Rd==EX_Rs.
  - Else ForwardA=01 if WB_RegWrite & WB_Rd!=0 & WB_Rd==EX_Rs.
  - Else ForwardA=00.
  - ForwardB uses the same rule with EX_Rt.
  - ForwardA and ForwardB are forced to 00 when FWD_EN=0.
- Redirect:
  - When M_Redirect=1: IFID_Flush=1, IDEX_Flush=1, EXMEM_Flush=1, PCWrite=1 (PC takes the target), IFID_Write=1.
  - A redirect overrides any stall in the same cycle; the stalled ID instruction is on the wrong path.
  - FlushCnt increments by 1 per redirect cycle.
- Priority, highest first: MemBusy freeze > HALTED freeze > redirect > stall > normal.
- Freeze (MemBusy=1, or halted with no step):
  - PCWrite=0, IFID_Write=0, PipeEn=0, all flushes=0.
  - Counters hold; a redirect pending in MEM is held and acted on when the freeze ends.
- Normal operation: PCWrite=1, IFID_Write=1, PipeEn=1, flushes=0.
- Stall/flush/forward outputs are combinational from the inputs and the current state. The FSM and counters are registered.
- FSM (transitions taken only when MemBusy=0; MemBusy holds the state):
  - RUN: go to HALTED if DbgHalt=1. The halt takes effect next cycle; the current cycle completes normally.
  - HALTED: Halted=1, pipeline frozen. If DbgStep=1, this cycle runs as a normal cycle (stall/redirect rules apply), then the state stays HALTED. If DbgHalt=0, go to RUN.
  - DbgStep is ignored in RUN. A DbgStep seen during a MemBusy cycle is discarded, not queued.
- Counters: StallCnt increments once per stall cycle actually applied (not while frozen). Both counters wrap from 0xFFFFFFFF to 0.

Decomposition:
- Shared package (pipeline_pkg):
  - forwarding-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding (RUN, HALTED);
  - REG_ZERO=5'd0.
- One sub-module: forward_unit, the combinational ForwardA/ForwardB generation. Everything else stays in pipeline_hazard_ctrl.

Test Plan:
- lw $2,0($1) then add $3,$2,$4 (EX_MemRead=1, EX_Rd=2, ID_Rs=2) -> one cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1; StallCnt 0->1; next cycle ForwardA=01.
- add $5,.. in MEM, sub reading $5 in EX (M_Rd=5, WB_Rd=5, both writing) -> ForwardA=10, MEM has priority; with EX_Rs=0 and M_Rd=0 -> ForwardA=00.
- M_Redirect=1 in the same cycle as a load-use condition -> IFID_Flush=IDEX_Flush=EXMEM_Flush=1, PCWrite=1, StallCnt unchanged, FlushCnt +1.
- FWD_EN=0, RF_BYPASS=0, add $2 then dependent or $6,$2,$2 -> exactly 3 stall cycles, StallCnt=3, ForwardA/B held at 00.
- DbgHalt=1 -> Halted=1 next cycle with PCWrite=0; three DbgStep pulses -> PC advances exactly 3 times; DbgHalt=0 -> RUN.
- MemBusy=1 for 4 cycles with M_Redirect=1 -> no flush and no counter change during busy; flush on the first cycle after MemBusy falls; assert Reset=0 mid-halt -> RUN, counters 0 immediately.
